// File: rtl/instr_seq_decode.sv
// PIC16F Q-cycle sequencer, program counter and instruction decoder.
// Executes IR while the next word is prefetched; taken branches and skips flush that prefetched word.
module instr_seq_decode #(
    parameter int              PC_W      = 13,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pm_addr,
    input  logic [13:0]     pm_data,
    output logic [1:0]      q_phase,
    output logic [6:0]      rf_addr,
    output logic [3:0]      alu_op,
    output logic            alu_d,
    output logic            alu_d_wr_en,
    output logic            alu_status_wr_en,
    output logic [2:0]      alu_b_in,
    output logic            alu_lit_sel,
    input  logic            alu_bit_test_res,
    input  logic            alu_out_z,
    input  logic [1:0]      pclath_hi,
    input  logic [PC_W-1:0] stack_top,
    output logic            stack_push,
    output logic            stack_pop,
    output logic [PC_W-1:0] stack_push_data
);

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_COM    = 4'd5;
    localparam logic [3:0] ALU_DEC    = 4'd6;
    localparam logic [3:0] ALU_INC    = 4'd7;
    localparam logic [3:0] ALU_PASSLF = 4'd8;
    localparam logic [3:0] ALU_PASSW  = 4'd9;
    localparam logic [3:0] ALU_RLF    = 4'd10;
    localparam logic [3:0] ALU_RRF    = 4'd11;
    localparam logic [3:0] ALU_SWAPF  = 4'd12;
    localparam logic [3:0] ALU_ZERO   = 4'd13;
    localparam logic [3:0] ALU_BC     = 4'd14;
    localparam logic [3:0] ALU_BS     = 4'd15;

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} q_t;

    q_t              q, q_next;
    logic [PC_W-1:0] pc, pc_next;
    logic [13:0]     ir;
    logic            flush, flush_next;

    logic dec_wr, dec_st_wr, dec_goto, dec_call, dec_ret, dec_skip_z, dec_skip_bit;
    logic active, skip_taken;

    always_ff @(posedge clk) begin
        if (rst) q <= Q1;
        else     q <= q_next;
    end

    always_comb begin
        q_next = Q1;
        case (q)
            Q1:      q_next = Q2;
            Q2:      q_next = Q3;
            Q3:      q_next = Q4;
            default: q_next = Q1;
        endcase
    end

    // Instruction decode: ALU controls plus the control-flow class of IR
    always_comb begin
        alu_op       = ALU_PASSW;
        alu_d        = ir[7];
        alu_lit_sel  = 1'b0;
        dec_wr       = 1'b0;
        dec_st_wr    = 1'b0;
        dec_goto     = 1'b0;
        dec_call     = 1'b0;
        dec_ret      = 1'b0;
        dec_skip_z   = 1'b0;
        dec_skip_bit = 1'b0;
        casez (ir)
            14'b00_0000_0000_1000,
            14'b00_0000_0000_1001: dec_ret = 1'b1;
            14'b00_0000_1???_????: begin alu_op = ALU_PASSW;  alu_d = 1'b1; dec_wr = 1'b1; end
            14'b00_0001_????_????: begin alu_op = ALU_ZERO;   dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_0010_????_????: begin alu_op = ALU_SUB;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_0011_????_????: begin alu_op = ALU_DEC;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_0100_????_????: begin alu_op = ALU_OR;     dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_0101_????_????: begin alu_op = ALU_AND;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_0110_????_????: begin alu_op = ALU_XOR;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_0111_????_????: begin alu_op = ALU_ADD;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_1000_????_????: begin alu_op = ALU_PASSLF; dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_1001_????_????: begin alu_op = ALU_COM;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_1010_????_????: begin alu_op = ALU_INC;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_1011_????_????: begin alu_op = ALU_DEC;    dec_wr = 1'b1; dec_skip_z = 1'b1; end
            14'b00_1100_????_????: begin alu_op = ALU_RRF;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_1101_????_????: begin alu_op = ALU_RLF;    dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b00_1110_????_????: begin alu_op = ALU_SWAPF;  dec_wr = 1'b1; end
            14'b00_1111_????_????: begin alu_op = ALU_INC;    dec_wr = 1'b1; dec_skip_z = 1'b1; end
            14'b01_00??_????_????: begin alu_op = ALU_BC; alu_d = 1'b1; dec_wr = 1'b1; end
            14'b01_01??_????_????: begin alu_op = ALU_BS; alu_d = 1'b1; dec_wr = 1'b1; end
            14'b01_10??_????_????: begin alu_op = ALU_BC; alu_d = 1'b1; dec_skip_bit = 1'b1; end
            14'b01_11??_????_????: begin alu_op = ALU_BS; alu_d = 1'b1; dec_skip_bit = 1'b1; end
            14'b10_0???_????_????: dec_call = 1'b1;
            14'b10_1???_????_????: dec_goto = 1'b1;
            14'b11_00??_????_????: begin alu_op = ALU_PASSLF; alu_lit_sel = 1'b1; alu_d = 1'b0; dec_wr = 1'b1; end
            14'b11_01??_????_????: begin
                alu_op = ALU_PASSLF; alu_lit_sel = 1'b1; alu_d = 1'b0; dec_wr = 1'b1; dec_ret = 1'b1;
            end
            14'b11_1000_????_????: begin alu_op = ALU_OR;  alu_lit_sel = 1'b1; alu_d = 1'b0; dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b11_1001_????_????: begin alu_op = ALU_AND; alu_lit_sel = 1'b1; alu_d = 1'b0; dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b11_1010_????_????: begin alu_op = ALU_XOR; alu_lit_sel = 1'b1; alu_d = 1'b0; dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b11_110?_????_????: begin alu_op = ALU_SUB; alu_lit_sel = 1'b1; alu_d = 1'b0; dec_wr = 1'b1; dec_st_wr = 1'b1; end
            14'b11_111?_????_????: begin alu_op = ALU_ADD; alu_lit_sel = 1'b1; alu_d = 1'b0; dec_wr = 1'b1; dec_st_wr = 1'b1; end
            default: ;
        endcase
    end

    // A flushed cycle still advances PC so the fetch stream stays in order
    always_comb begin
        skip_taken = (dec_skip_z & alu_out_z) | (dec_skip_bit & alu_bit_test_res);
        pc_next    = pc + PC_W'(1);
        flush_next = 1'b0;
        if (!flush) begin
            if (dec_goto || dec_call) begin
                pc_next    = PC_W'({pclath_hi, ir[10:0]});
                flush_next = 1'b1;
            end else if (dec_ret) begin
                pc_next    = stack_top;
                flush_next = 1'b1;
            end else if (skip_taken) begin
                flush_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_VEC;
            ir    <= 14'h0000;
            flush <= 1'b1;
        end else if (q == Q4) begin
            ir    <= pm_data;
            pc    <= pc_next;
            flush <= flush_next;
        end
    end

    assign active           = (q == Q4) && !flush && !rst;
    assign alu_d_wr_en      = active & dec_wr;
    assign alu_status_wr_en = active & dec_st_wr;
    assign stack_push       = active & dec_call;
    assign stack_pop        = active & dec_ret;
    assign stack_push_data  = pc;
    assign pm_addr          = pc;
    assign q_phase          = q;
    assign rf_addr          = ir[6:0];
    assign alu_b_in         = ir[9:7];

endmodule

// File: tb/tb_instr_seq_decode.sv
// Bench for instr_seq_decode: directed program snippets plus a random program run,
// checked against an instruction-level model of the fetch/execute flow.
module tb_instr_seq_decode;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_COM    = 4'd5;
    localparam logic [3:0] ALU_DEC    = 4'd6;
    localparam logic [3:0] ALU_INC    = 4'd7;
    localparam logic [3:0] ALU_PASSLF = 4'd8;
    localparam logic [3:0] ALU_PASSW  = 4'd9;
    localparam logic [3:0] ALU_RLF    = 4'd10;
    localparam logic [3:0] ALU_RRF    = 4'd11;
    localparam logic [3:0] ALU_SWAPF  = 4'd12;
    localparam logic [3:0] ALU_ZERO   = 4'd13;
    localparam logic [3:0] ALU_BC     = 4'd14;
    localparam logic [3:0] ALU_BS     = 4'd15;

    // Byte-oriented ops indexed by opcode bits [11:8]; status-write mask uses the same index
    localparam logic [3:0] BYTE_OP [0:15] = '{ALU_PASSW, ALU_ZERO, ALU_SUB, ALU_DEC, ALU_OR, ALU_AND,
        ALU_XOR, ALU_ADD, ALU_PASSLF, ALU_COM, ALU_INC, ALU_DEC, ALU_RRF, ALU_RLF, ALU_SWAPF, ALU_INC};
    localparam logic [15:0] BYTE_ST = 16'h37FE;
    localparam logic [3:0] LIT_OP [0:15] = '{ALU_PASSLF, ALU_PASSLF, ALU_PASSLF, ALU_PASSLF,
        ALU_PASSLF, ALU_PASSLF, ALU_PASSLF, ALU_PASSLF, ALU_OR, ALU_AND, ALU_XOR, ALU_PASSLF,
        ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD};

    localparam logic [13:0] W_ADDLW5 = 14'h3E05;

    typedef struct packed {
        logic       alu;
        logic [3:0] op;
        logic       d;
        logic       lit;
        logic       wr;
        logic       st;
        logic       jump;
        logic       call;
        logic       ret;
        logic       skz;
        logic       skb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] pm_addr;
    logic [13:0] pm_data;
    logic [1:0]  q_phase;
    logic [6:0]  rf_addr;
    logic [3:0]  alu_op;
    logic        alu_d, alu_d_wr_en, alu_status_wr_en, alu_lit_sel;
    logic [2:0]  alu_b_in;
    logic        alu_bit_test_res = 1'b0;
    logic        alu_out_z = 1'b0;
    logic [1:0]  pclath_hi = 2'b00;
    logic [12:0] stack_top = 13'h0;
    logic        stack_push, stack_pop;
    logic [12:0] stack_push_data;
    logic [3:0]  en_vec;

    logic [13:0] mem [0:8191];

    logic [12:0] m_pc;
    logic [13:0] m_word;
    logic        m_squash;
    logic [12:0] stk [$];

    logic        rand_mode = 1'b0;
    logic        dir_z = 1'b0, dir_bit = 1'b0;
    logic [1:0]  dir_pclath = 2'b00;

    logic [3:0]  q4_en, q4_op;
    logic        q4_d, q4_lit;
    logic [12:0] q4_push_data;

    int checks = 0;
    int fails  = 0;

    assign pm_data = mem[pm_addr];
    assign en_vec  = {alu_d_wr_en, alu_status_wr_en, stack_push, stack_pop};

    always #5 clk = ~clk;

    instr_seq_decode #(.PC_W(13), .RESET_VEC(13'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .pm_addr          (pm_addr),
        .pm_data          (pm_data),
        .q_phase          (q_phase),
        .rf_addr          (rf_addr),
        .alu_op           (alu_op),
        .alu_d            (alu_d),
        .alu_d_wr_en      (alu_d_wr_en),
        .alu_status_wr_en (alu_status_wr_en),
        .alu_b_in         (alu_b_in),
        .alu_lit_sel      (alu_lit_sel),
        .alu_bit_test_res (alu_bit_test_res),
        .alu_out_z        (alu_out_z),
        .pclath_hi        (pclath_hi),
        .stack_top        (stack_top),
        .stack_push       (stack_push),
        .stack_pop        (stack_pop),
        .stack_push_data  (stack_push_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // What the instruction set says a word does, independent of any pipeline detail
    function automatic exp_t spec_of(input logic [13:0] w);
        exp_t e;
        int   grp;
        int   sub;
        e   = '0;
        grp = int'(w >> 12);
        sub = int'((w >> 8) & 14'h000F);
        case (grp)
            0: begin
                if (sub == 0 && w[7] == 1'b0) begin
                    e.ret = (w == 14'h0008) || (w == 14'h0009);
                end else begin
                    e.alu = 1'b1;
                    e.op  = BYTE_OP[sub];
                    e.d   = (sub == 0) ? 1'b1 : w[7];
                    e.wr  = 1'b1;
                    e.st  = BYTE_ST[sub];
                    e.skz = (sub == 11) || (sub == 15);
                end
            end
            1: begin
                e.alu = 1'b1;
                e.op  = w[10] ? ALU_BS : ALU_BC;
                e.d   = 1'b1;
                e.wr  = !w[11];
                e.skb = w[11];
            end
            2: begin
                e.jump = 1'b1;
                e.call = !w[11];
            end
            default: begin
                if (sub != 11) begin
                    e.alu = 1'b1;
                    e.lit = 1'b1;
                    e.wr  = 1'b1;
                    e.op  = LIT_OP[sub];
                    e.st  = (sub >= 8);
                    e.ret = (sub >= 4) && (sub <= 7);
                end
            end
        endcase
        return e;
    endfunction

    task automatic applyStimulus();
        if (rand_mode) begin
            alu_out_z        = 1'($urandom_range(0, 1));
            alu_bit_test_res = 1'($urandom_range(0, 1));
            pclath_hi        = 2'($urandom_range(0, 3));
        end else begin
            alu_out_z        = dir_z;
            alu_bit_test_res = dir_bit;
            pclath_hi        = dir_pclath;
        end
        if (stk.size() > 0) stack_top = stk[$];
        else                stack_top = rand_mode ? 13'($urandom) : 13'h0;
    endtask

    task automatic fill_mem(input logic [13:0] w);
        for (int i = 0; i < 8192; i++) mem[i] = w;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_q_phase", 32'(q_phase), 32'd0);
        checkOutput("rst_pm_addr", 32'(pm_addr), 32'd0);
        checkOutput("rst_enables", 32'(en_vec), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_pc     = 13'h0;
        m_word   = 14'h0;
        m_squash = 1'b1;
        stk.delete();
    endtask

    // One instruction cycle starting just after the edge that enters Q1
    task automatic run_cycle();
        exp_t        e;
        logic [12:0] top_val;
        logic [13:0] fetched;
        logic [3:0]  exp_en;
        applyStimulus();
        top_val = stack_top;
        e       = spec_of(m_word);
        for (int ph = 0; ph < 4; ph++) begin
            @(negedge clk);
            checkOutput("q_phase", 32'(q_phase), 32'(ph));
            checkOutput("pm_addr", 32'(pm_addr), 32'(m_pc));
            if (ph < 3) begin
                checkOutput("early_enables", 32'(en_vec), 32'd0);
            end else begin
                exp_en = m_squash ? 4'b0000 : {e.wr, e.st, e.call, e.ret};
                checkOutput("q4_enables", 32'(en_vec), 32'(exp_en));
                q4_en        = en_vec;
                q4_op        = alu_op;
                q4_d         = alu_d;
                q4_lit       = alu_lit_sel;
                q4_push_data = stack_push_data;
                if (!m_squash) begin
                    checkOutput("rf_addr", 32'(rf_addr), 32'(m_word[6:0]));
                    checkOutput("alu_b_in", 32'(alu_b_in), 32'(m_word[9:7]));
                end
                if (!m_squash && e.alu) begin
                    checkOutput("alu_op", 32'(alu_op), 32'(e.op));
                    checkOutput("alu_d", 32'(alu_d), 32'(e.d));
                    checkOutput("alu_lit_sel", 32'(alu_lit_sel), 32'(e.lit));
                end
                if (!m_squash && e.call)
                    checkOutput("push_data", 32'(stack_push_data), 32'(m_pc));
            end
            @(posedge clk);
            #1;
        end
        fetched = mem[m_pc];
        if (m_squash) begin
            m_pc++;
            m_squash = 1'b0;
        end else if (e.jump) begin
            if (e.call) stk.push_back(m_pc);
            m_pc     = {pclath_hi, m_word[10:0]};
            m_squash = 1'b1;
        end else if (e.ret) begin
            m_pc = top_val;
            if (stk.size() > 0) void'(stk.pop_back());
            m_squash = 1'b1;
        end else begin
            m_squash = (e.skz && alu_out_z) || (e.skb && alu_bit_test_res);
            m_pc++;
        end
        m_word = fetched;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // First word after reset runs one cycle late; the reset cycle is a NOP
        fill_mem(14'h0000);
        mem[0] = W_ADDLW5;
        apply_reset();
        run_cycle();
        checkOutput("addlw_c1_en", 32'(q4_en), 32'd0);
        run_cycle();
        checkOutput("addlw_en", 32'(q4_en), 32'b1100);
        checkOutput("addlw_op", 32'(q4_op), 32'(ALU_ADD));
        checkOutput("addlw_lit", 32'(q4_lit), 32'd1);
        checkOutput("addlw_d", 32'(q4_d), 32'd0);

        // GOTO 0x123 with PCLATH high bits 01; the prefetched ADDLW must be flushed
        fill_mem(14'h0000);
        mem[0]      = 14'h2923;
        mem[1]      = W_ADDLW5;
        mem[13'h923] = W_ADDLW5;
        dir_pclath  = 2'b01;
        apply_reset();
        repeat (2) run_cycle();
        checkOutput("goto_target", 32'(pm_addr), 32'h923);
        run_cycle();
        checkOutput("goto_flush_en", 32'(q4_en), 32'd0);
        run_cycle();
        checkOutput("goto_dest_en", 32'(q4_en), 32'b1100);

        // CALL 0x010 from 0x005, then RETURN back to 0x006
        fill_mem(14'h0000);
        mem[5]     = 14'h2010;
        mem[16]    = 14'h0008;
        dir_pclath = 2'b00;
        apply_reset();
        repeat (6) run_cycle();
        run_cycle();
        checkOutput("call_push", 32'(q4_en), 32'b0010);
        checkOutput("call_push_data", 32'(q4_push_data), 32'h006);
        checkOutput("call_target", 32'(pm_addr), 32'h010);
        repeat (2) run_cycle();
        checkOutput("return_pop", 32'(q4_en), 32'b0001);
        checkOutput("return_target", 32'(pm_addr), 32'h006);

        // DECFSZ 0x20,f with zero result skips, with nonzero result does not
        fill_mem(14'h0000);
        mem[0] = 14'h0BA0;
        mem[1] = W_ADDLW5;
        dir_z  = 1'b1;
        apply_reset();
        repeat (2) run_cycle();
        checkOutput("decfsz_z1_en", 32'(q4_en), 32'b1000);
        run_cycle();
        checkOutput("decfsz_skip_en", 32'(q4_en), 32'd0);
        dir_z = 1'b0;
        apply_reset();
        repeat (2) run_cycle();
        checkOutput("decfsz_z0_en", 32'(q4_en), 32'b1000);
        run_cycle();
        checkOutput("decfsz_noskip_en", 32'(q4_en), 32'b1100);

        // BTFSS f,3 with bit set skips the ADDLW; BSF f,3 writes back to f
        fill_mem(14'h0000);
        mem[0]  = 14'h1DA0;
        mem[1]  = W_ADDLW5;
        mem[2]  = 14'h15A0;
        dir_bit = 1'b1;
        apply_reset();
        repeat (2) run_cycle();
        checkOutput("btfss_en", 32'(q4_en), 32'd0);
        run_cycle();
        checkOutput("btfss_skip_en", 32'(q4_en), 32'd0);
        run_cycle();
        checkOutput("bsf_en", 32'(q4_en), 32'b1000);
        checkOutput("bsf_d", 32'(q4_d), 32'd1);
        checkOutput("bsf_op", 32'(q4_op), 32'(ALU_BS));
        dir_bit = 1'b0;

        // Jump to the last address and let PC wrap to zero
        fill_mem(14'h0000);
        mem[0]     = 14'h2FFF;
        dir_pclath = 2'b11;
        apply_reset();
        repeat (2) run_cycle();
        checkOutput("wrap_at_top", 32'(pm_addr), 32'h1FFF);
        run_cycle();
        checkOutput("wrap_to_zero", 32'(pm_addr), 32'h0000);
        run_cycle();
        dir_pclath = 2'b00;

        // Reset arriving mid-cycle discards the instruction in flight
        fill_mem(W_ADDLW5);
        apply_reset();
        repeat (3) run_cycle();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_q4_phase", 32'(q_phase), 32'd3);
        checkOutput("rst_q4_enables", 32'(en_vec), 32'd0);
        apply_reset();
        repeat (2) run_cycle();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_q3_phase", 32'(q_phase), 32'd2);
        checkOutput("rst_q3_enables", 32'(en_vec), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_q", 32'(q_phase), 32'd0);
        checkOutput("rst_mid_pc", 32'(pm_addr), 32'd0);
        checkOutput("rst_mid_enables", 32'(en_vec), 32'd0);
        apply_reset();
        repeat (2) run_cycle();

        // Random program with random ALU feedback and PCLATH
        for (int i = 0; i < 8192; i++) mem[i] = 14'($urandom);
        rand_mode = 1'b1;
        apply_reset();
        repeat (1500) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
